k12a_io_mailbox: RTL and testbench
==================================

// Module: k12a_io_mailbox
// PURPOSE
//  IO-bus responder answering the CPU FSM's io_load/io_store strobes (in/out instructions,
//  port = inst[2:0]). Buffers bytes between the K12a core and an external host through two
//  FIFOs: RX (host->CPU) and TX (CPU->host). Drives the FSM's wake input to end STATE_HALT.
// PARAMETERS
//  DEPTH_LOG2  3     log2 of entries per FIFO (DEPTH = 2**DEPTH_LOG2)
//  PORT_HI     1'b0  block responds only when io_addr[2] == PORT_HI
// PORTS
//  clock          in   1  system clock; all state changes on rising edge
//  reset_n        in   1  asynchronous active-low reset
//  io_addr        in   3  IO port number (inst[2:0])
//  io_load        in   1  CPU reads port this cycle (in)
//  io_store       in   1  CPU writes port this cycle (out)
//  data_in        in   8  data bus value during io_store (register a)
//  data_out       out  8  read data onto data bus
//  data_out_en    out  1  high when block is driving data_out
//  wake           out  1  wake request to CPU FSM
//  host_rx_data   in   8  host byte toward CPU
//  host_rx_valid  in   1  host offers host_rx_data
//  host_rx_ready  out  1  RX FIFO can accept
//  host_tx_data   out  8  head of TX FIFO
//  host_tx_valid  out  1  TX FIFO non-empty
//  host_tx_ready  in   1  host consumes host_tx_data
// BEHAVIOUR
//  Reset (async, reset_n=0): both FIFOs empty, pointers/counts 0, CTRL=0, sticky flags 0;
//   outputs: data_out=0, data_out_en=0, wake=0, host_rx_ready=1, host_tx_valid=0, host_tx_data=0.
//   Reset mid-transfer discards all buffered data; no partial push/pop survives.
//  sel = (io_addr[2]==PORT_HI). Register map on io_addr[1:0]:
//   0 RXDATA  R: head of RX (0x00 if empty); pop at clock edge. W: ignored.
//   1 STATUS  R: {2'b0, tx_ovf, rx_unf, tx_full, tx_nonempty, rx_full, rx_nonempty}.
//             W: write-1-to-clear bits [5:4]; other bits ignored.
//   2 TXDATA  W: push data_in to TX at clock edge. R: returns 0x00, no effect.
//   3 CTRL    R/W: [0] wake_on_rx, [1] wake_on_tx_empty, [7:2] read 0.
//  Reads are combinational, zero latency: data_out/data_out_en valid same cycle as io_load&sel,
//   so the FSM latches a on the same edge. data_out=0, data_out_en=0 when not io_load&sel.
//  Side effects (pop, push, W1C, CTRL write) take effect on the edge ending the strobe cycle.
//  io_load&io_store together (never issued by FSM): store effect only; no pop, data_out still driven.
//  RX FIFO: push when host_rx_valid&host_rx_ready. host_rx_ready = (rx_count != DEPTH), from
//   registered count only (not relieved by a same-cycle pop). Read of empty RX: returns 0x00,
//   no pop, sets rx_unf sticky; a same-cycle host push still occurs.
//  TX FIFO: pop when host_tx_valid&host_tx_ready. CPU write when tx_count==DEPTH: byte dropped,
//   tx_ovf sticky set, even if host pops same cycle.
//  Simultaneous push+pop on non-empty/non-full FIFO: both occur, count unchanged.
//  Counts are DEPTH_LOG2+1 bits; pointers DEPTH_LOG2 bits, wrap DEPTH-1 -> 0.
//  Sticky set and W1C clear same cycle: set wins.
//  wake = (CTRL[0] & rx_nonempty) | (CTRL[1] & ~tx_nonempty), combinational from registered state;
//   level, held until cause removed or CTRL cleared.
// TESTING
//  1 reset; host pushes 0x11,0x22; in port0 twice -> reads 0x11 then 0x22; STATUS reads 0x00.
//  2 host pushes 8 bytes with DEPTH_LOG2=3 -> host_rx_ready=0 after 8th; 9th held; one CPU pop
//    -> ready=1 next cycle; pointer wrap verified over 20 bytes, order preserved.
//  3 out port2 with 0xA5 while host_tx_ready=0, 9 writes -> STATUS=0x2C (tx_ovf,full,nonempty);
//    write 0x20 to STATUS -> 0x0C; host drains 8 bytes, first 0xA5.
//  4 in port0 when empty -> returns 0x00, STATUS bit4 set; same cycle host push 0x7E -> RX count 1.
//  5 CTRL=0x01, CPU halted, host pushes 0x55 -> wake=1 the cycle after push edge; pop -> wake=0.
//  6 reset_n pulsed low mid-stream with 3 bytes in each FIFO -> all outputs at reset values at once.

Source files
------------

// File: rtl/k12a_io_mailbox.sv
// K12a IO-bus mailbox: answers in/out strobes and buffers bytes between the core and an
// external host through an RX FIFO (host->CPU) and a TX FIFO (CPU->host).
module k12a_io_mailbox #(
  parameter int   DEPTH_LOG2 = 3,
  parameter logic PORT_HI    = 1'b0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [2:0] io_addr,
  input  logic       io_load,
  input  logic       io_store,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_out_en,
  output logic       wake,
  input  logic [7:0] host_rx_data,
  input  logic       host_rx_valid,
  output logic       host_rx_ready,
  output logic [7:0] host_tx_data,
  output logic       host_tx_valid,
  input  logic       host_tx_ready
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0]      FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = (DEPTH_LOG2)'(1);

  localparam logic [1:0] REG_RXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_TXDATA = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  logic [7:0]            rx_mem [DEPTH];
  logic [7:0]            tx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rx_wr_ptr_reg, rx_rd_ptr_reg, tx_wr_ptr_reg, tx_rd_ptr_reg;
  logic [CNT_W-1:0]      rx_count_reg, tx_count_reg;
  logic                  rx_unf_reg, tx_ovf_reg;
  logic [1:0]            ctrl_reg;

  logic       sel, cpu_rd, cpu_wr;
  logic [1:0] reg_addr;
  logic       rx_nonempty, rx_full, tx_nonempty, tx_full;
  logic       rx_push, rx_pop, rx_unf_set;
  logic       tx_push, tx_pop, tx_wr_req, tx_ovf_set;
  logic       status_wr, ctrl_wr;
  logic [7:0] status;

  // A simultaneous load+store is treated as a store: the read side effects are suppressed.
  assign sel      = (io_addr[2] == PORT_HI);
  assign reg_addr = io_addr[1:0];
  assign cpu_rd   = io_load & sel & ~io_store;
  assign cpu_wr   = io_store & sel;

  assign rx_nonempty = (rx_count_reg != '0);
  assign rx_full     = (rx_count_reg == FULL_COUNT);
  assign tx_nonempty = (tx_count_reg != '0);
  assign tx_full     = (tx_count_reg == FULL_COUNT);

  assign rx_push    = host_rx_valid & ~rx_full;
  assign rx_pop     = cpu_rd & (reg_addr == REG_RXDATA) & rx_nonempty;
  assign rx_unf_set = cpu_rd & (reg_addr == REG_RXDATA) & ~rx_nonempty;

  // A write into a full TX FIFO is dropped even if the host frees a slot on the same edge.
  assign tx_pop     = tx_nonempty & host_tx_ready;
  assign tx_wr_req  = cpu_wr & (reg_addr == REG_TXDATA);
  assign tx_push    = tx_wr_req & ~tx_full;
  assign tx_ovf_set = tx_wr_req & tx_full;

  assign status_wr = cpu_wr & (reg_addr == REG_STATUS);
  assign ctrl_wr   = cpu_wr & (reg_addr == REG_CTRL);
  assign status    = {2'b00, tx_ovf_reg, rx_unf_reg, tx_full, tx_nonempty, rx_full, rx_nonempty};

  assign host_rx_ready = ~rx_full;
  assign host_tx_valid = tx_nonempty;
  assign host_tx_data  = tx_nonempty ? tx_mem[tx_rd_ptr_reg] : 8'h00;
  assign wake          = (ctrl_reg[0] & rx_nonempty) | (ctrl_reg[1] & ~tx_nonempty);
  assign data_out_en   = io_load & sel;

  always_comb begin
    data_out = 8'h00;
    if (data_out_en) begin
      unique case (reg_addr)
        REG_RXDATA: data_out = rx_nonempty ? rx_mem[rx_rd_ptr_reg] : 8'h00;
        REG_STATUS: data_out = status;
        REG_TXDATA: data_out = 8'h00;
        REG_CTRL:   data_out = {6'b000000, ctrl_reg};
        default:    data_out = 8'h00;
      endcase
    end
  end

  // Storage arrays carry no reset; emptiness is defined entirely by the counts.
  always_ff @(posedge clock) begin
    if (rx_push) rx_mem[rx_wr_ptr_reg] <= host_rx_data;
    if (tx_push) tx_mem[tx_wr_ptr_reg] <= data_in;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_wr_ptr_reg <= '0;
      rx_rd_ptr_reg <= '0;
      rx_count_reg  <= '0;
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
      tx_count_reg  <= '0;
      rx_unf_reg    <= 1'b0;
      tx_ovf_reg    <= 1'b0;
      ctrl_reg      <= 2'b00;
    end else begin
      if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + PTR_ONE;
      if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + PTR_ONE;
      if (rx_push && !rx_pop)      rx_count_reg <= rx_count_reg + CNT_ONE;
      else if (!rx_push && rx_pop) rx_count_reg <= rx_count_reg - CNT_ONE;

      if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + PTR_ONE;
      if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + PTR_ONE;
      if (tx_push && !tx_pop)      tx_count_reg <= tx_count_reg + CNT_ONE;
      else if (!tx_push && tx_pop) tx_count_reg <= tx_count_reg - CNT_ONE;

      // Setting a sticky flag beats a write-1-to-clear on the same edge.
      if (rx_unf_set)                      rx_unf_reg <= 1'b1;
      else if (status_wr && data_in[4])    rx_unf_reg <= 1'b0;
      if (tx_ovf_set)                      tx_ovf_reg <= 1'b1;
      else if (status_wr && data_in[5])    tx_ovf_reg <= 1'b0;

      if (ctrl_wr) ctrl_reg <= data_in[1:0];
    end
  end

endmodule

// File: tb/tb_k12a_io_mailbox.sv
// Self-checking bench for k12a_io_mailbox: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_k12a_io_mailbox;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [2:0] io_addr;
  logic       io_load, io_store;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_out_en, wake;
  logic [7:0] host_rx_data;
  logic       host_rx_valid, host_rx_ready;
  logic [7:0] host_tx_data;
  logic       host_tx_valid, host_tx_ready;

  int n_checks = 0;
  int n_errors = 0;

  k12a_io_mailbox #(.DEPTH_LOG2(3), .PORT_HI(1'b0)) dut (
    .clock(clock), .reset_n(reset_n),
    .io_addr(io_addr), .io_load(io_load), .io_store(io_store), .data_in(data_in),
    .data_out(data_out), .data_out_en(data_out_en), .wake(wake),
    .host_rx_data(host_rx_data), .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready),
    .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid), .host_tx_ready(host_tx_ready)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0] addr;
    logic       ld, st;
    logic [7:0] din, hrx;
    logic       hrxv, htxr;
    logic [7:0] e_do;
    logic       e_en, e_rdy, e_txv, e_wake;
  } vec_t;
  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] a, input logic ld, input logic st, input logic [7:0] d,
                       input logic [7:0] hd, input logic hv, input logic hr);
    io_addr = a; io_load = ld; io_store = st; data_in = d;
    host_rx_data = hd; host_rx_valid = hv; host_tx_ready = hr;
  endtask

  task automatic idle();
    drive(3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  // Behavioural reference: plain queues plus sticky bits and the control byte.
  byte unsigned rxq[$];
  byte unsigned txq[$];
  bit           m_unf, m_ovf;
  bit [1:0]     m_ctrl;

  function automatic logic [7:0] m_status();
    return {2'b00, m_ovf, m_unf, txq.size() == 8, txq.size() != 0, rxq.size() == 8, rxq.size() != 0};
  endfunction

  function automatic logic [7:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return (rxq.size() != 0) ? rxq[0] : 8'h00;
      2'd1:    return m_status();
      2'd3:    return {6'b0, m_ctrl};
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_check(input int cyc);
    logic sel;
    sel = (io_addr[2] == 1'b0);
    chk($sformatf("rnd%0d data_out_en", cyc), data_out_en, io_load && sel);
    chk($sformatf("rnd%0d data_out", cyc), data_out, (io_load && sel) ? m_read(io_addr[1:0]) : 8'h00);
    chk($sformatf("rnd%0d host_rx_ready", cyc), host_rx_ready, rxq.size() != 8);
    chk($sformatf("rnd%0d host_tx_valid", cyc), host_tx_valid, txq.size() != 0);
    chk($sformatf("rnd%0d host_tx_data", cyc), host_tx_data, (txq.size() != 0) ? txq[0] : 8'h00);
    chk($sformatf("rnd%0d wake", cyc), wake, (m_ctrl[0] && rxq.size() != 0) || (m_ctrl[1] && txq.size() == 0));
  endtask

  // Applies the effect of the current inputs at the coming clock edge.
  task automatic m_update();
    bit sel, rd_only, wr, rx_was_full, tx_was_full, unf_set, ovf_set;
    byte unsigned dropped;
    sel = (io_addr[2] == 1'b0);
    rd_only = sel && io_load && !io_store;
    wr = sel && io_store;
    rx_was_full = (rxq.size() == 8);
    tx_was_full = (txq.size() == 8);
    unf_set = rd_only && io_addr[1:0] == 2'd0 && rxq.size() == 0;
    ovf_set = wr && io_addr[1:0] == 2'd2 && tx_was_full;
    if (rd_only && io_addr[1:0] == 2'd0 && rxq.size() != 0) dropped = rxq.pop_front();
    if (host_rx_valid && !rx_was_full) rxq.push_back(host_rx_data);
    if (host_tx_ready && txq.size() != 0) dropped = txq.pop_front();
    if (wr && io_addr[1:0] == 2'd2 && !tx_was_full) txq.push_back(data_in);
    if (wr && io_addr[1:0] == 2'd1) begin
      if (data_in[4]) m_unf = 1'b0;
      if (data_in[5]) m_ovf = 1'b0;
    end
    if (unf_set) m_unf = 1'b1;
    if (ovf_set) m_ovf = 1'b1;
    if (wr && io_addr[1:0] == 2'd3) m_ctrl = data_in[1:0];
  endtask

  initial begin
    // addr ld st din hrx hrxv htxr | do en rdy txv wake
    vecs[0]  = '{3'd0, 1'b0, 1'b0, 8'h00, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{3'd0, 1'b0, 1'b0, 8'h00, 8'h22, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{3'd0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{3'd0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{3'd1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{3'd0, 1'b1, 1'b0, 8'h00, 8'h7E, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{3'd1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{3'd1, 1'b0, 1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{3'd1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{3'd0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h7E, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{3'd3, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{3'd3, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h03, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{3'd2, 1'b0, 1'b1, 8'h5A, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{3'd2, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[16] = '{3'd7, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[17] = '{3'd3, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[18] = '{3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};

    reset_n = 1'b0;
    idle();
    #2;
    chk("reset data_out", data_out, 8'h00);
    chk("reset data_out_en", data_out_en, 1'b0);
    chk("reset wake", wake, 1'b0);
    chk("reset host_rx_ready", host_rx_ready, 1'b1);
    chk("reset host_tx_valid", host_tx_valid, 1'b0);
    chk("reset host_tx_data", host_tx_data, 8'h00);
    do_reset();

    // Vector table: basic reads, empty-read underflow with concurrent push, W1C, CTRL, wake.
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].addr, vecs[i].ld, vecs[i].st, vecs[i].din, vecs[i].hrx, vecs[i].hrxv, vecs[i].htxr);
      #2;
      chk($sformatf("vec%0d data_out", i), data_out, vecs[i].e_do);
      chk($sformatf("vec%0d data_out_en", i), data_out_en, vecs[i].e_en);
      chk($sformatf("vec%0d host_rx_ready", i), host_rx_ready, vecs[i].e_rdy);
      chk($sformatf("vec%0d host_tx_valid", i), host_tx_valid, vecs[i].e_txv);
      chk($sformatf("vec%0d wake", i), wake, vecs[i].e_wake);
      step();
    end

    // RX fill to full, backpressure from registered count, wrap over 20 bytes.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(3'd0, 1'b0, 1'b0, 8'h00, 8'(8'h30 + i), 1'b1, 1'b0);
      #2;
      chk($sformatf("fill%0d host_rx_ready", i), host_rx_ready, 1'b1);
      step();
    end
    drive(3'd1, 1'b1, 1'b0, 8'h00, 8'h38, 1'b1, 1'b0);
    #2;
    chk("full host_rx_ready", host_rx_ready, 1'b0);
    chk("full status", data_out, 8'h03);
    step();
    drive(3'd0, 1'b1, 1'b0, 8'h00, 8'h38, 1'b1, 1'b0);
    #2;
    chk("full pop data", data_out, 8'h30);
    chk("pop-cycle host_rx_ready", host_rx_ready, 1'b0);
    step();
    drive(3'd0, 1'b0, 1'b0, 8'h00, 8'h38, 1'b1, 1'b0);
    #2;
    chk("after-pop host_rx_ready", host_rx_ready, 1'b1);
    step();
    drive(3'd0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    #2;
    chk("wrap pop 0x31", data_out, 8'h31);
    step();
    for (int j = 0; j < 11; j++) begin
      drive(3'd0, 1'b1, 1'b0, 8'h00, 8'(8'h39 + j), 1'b1, 1'b0);
      #2;
      chk($sformatf("wrap pushpop%0d", j), data_out, 8'(8'h32 + j));
      step();
    end
    for (int j = 0; j < 7; j++) begin
      drive(3'd0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      #2;
      chk($sformatf("wrap drain%0d", j), data_out, 8'(8'h3D + j));
      step();
    end
    drive(3'd1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    #2;
    chk("wrap end status", data_out, 8'h00);
    step();

    // TX overflow, W1C of tx_ovf, host drain order.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(3'd2, 1'b0, 1'b1, (i == 0) ? 8'hA5 : 8'(i), 8'h00, 1'b0, 1'b0);
      step();
    end
    drive(3'd1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    #2;
    chk("ovf status", data_out, 8'h2C);
    step();
    drive(3'd1, 1'b0, 1'b1, 8'h20, 8'h00, 1'b0, 1'b0);
    step();
    drive(3'd1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    #2;
    chk("w1c status", data_out, 8'h0C);
    step();
    for (int i = 0; i < 8; i++) begin
      drive(3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      #2;
      chk($sformatf("drain%0d host_tx_valid", i), host_tx_valid, 1'b1);
      chk($sformatf("drain%0d host_tx_data", i), host_tx_data, (i == 0) ? 8'hA5 : 8'(i));
      step();
    end
    #2;
    chk("drained host_tx_valid", host_tx_valid, 1'b0);

    // Wake on RX data while halted; cleared by the pop.
    do_reset();
    drive(3'd3, 1'b0, 1'b1, 8'h01, 8'h00, 1'b0, 1'b0);
    step();
    drive(3'd0, 1'b0, 1'b0, 8'h00, 8'h55, 1'b1, 1'b0);
    #2;
    chk("wake before push edge", wake, 1'b0);
    step();
    idle();
    #2;
    chk("wake after push", wake, 1'b1);
    step();
    #2;
    chk("wake held", wake, 1'b1);
    drive(3'd0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    #1;
    chk("wake pop data", data_out, 8'h55);
    step();
    idle();
    #2;
    chk("wake after pop", wake, 1'b0);
    step();

    // Asynchronous reset mid-stream with data in both FIFOs.
    do_reset();
    drive(3'd3, 1'b0, 1'b1, 8'h01, 8'h00, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(3'd2, 1'b0, 1'b1, 8'(8'hC0 + i), 8'(8'hB0 + i), 1'b1, 1'b0);
      step();
    end
    idle();
    #2;
    chk("pre-reset host_tx_valid", host_tx_valid, 1'b1);
    chk("pre-reset wake", wake, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("async reset host_tx_valid", host_tx_valid, 1'b0);
    chk("async reset host_tx_data", host_tx_data, 8'h00);
    chk("async reset host_rx_ready", host_rx_ready, 1'b1);
    chk("async reset wake", wake, 1'b0);
    chk("async reset data_out", data_out, 8'h00);
    chk("async reset data_out_en", data_out_en, 1'b0);
    step();
    reset_n = 1'b1;
    drive(3'd1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    #2;
    chk("post-reset status", data_out, 8'h00);
    step();

    // Randomized run against the reference model, with phases biasing fill and drain.
    do_reset();
    rxq.delete();
    txq.delete();
    m_unf = 1'b0;
    m_ovf = 1'b0;
    m_ctrl = 2'b00;
    for (int n = 0; n < 3000; n++) begin
      int pv, pr, r;
      pv = ((n / 300) % 2 == 0) ? 80 : 20;
      pr = ((n / 450) % 2 == 0) ? 15 : 85;
      r = int'($urandom_range(0, 15));
      drive(3'($urandom_range(0, 7)), (r < 6) || (r == 12), (r >= 6 && r < 12) || (r == 12),
            8'($urandom), 8'($urandom), int'($urandom_range(0, 99)) < pv,
            int'($urandom_range(0, 99)) < pr);
      #2;
      m_check(n);
      m_update();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
